// File: rtl/divider_nbit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the CALC phase.
module divider_nbit #(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [1:0]   i_op,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_result,
    output logic         o_div_by_zero
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [1:0]     r_op;
    logic [N-1:0]   r_quo;      // holds |A| on load; quotient bits shift in at the LSB
    logic [N-1:0]   r_rem;
    logic [N-1:0]   r_div;
    logic [N-1:0]   r_a_orig;
    logic [CW-1:0]  r_count;
    logic           r_sign_q;
    logic           r_sign_r;
    logic           r_b_zero;
    logic           r_ovf;
    logic           r_busy;
    logic           r_done;
    logic [N-1:0]   r_result;
    logic           r_dbz;

    logic           w_signed;
    logic [N-1:0]   w_abs_a;
    logic [N-1:0]   w_abs_b;
    logic           w_start_dbz;
    logic           w_start_ovf;
    logic [N:0]     w_trial;
    logic           w_borrow;
    logic [N-1:0]   w_quo_fix;
    logic [N-1:0]   w_rem_fix;

    assign w_signed    = ~i_op[0];
    assign w_abs_a     = (w_signed && i_a[N-1]) ? -i_a : i_a;
    assign w_abs_b     = (w_signed && i_b[N-1]) ? -i_b : i_b;
    assign w_start_dbz = (i_b == '0);
    assign w_start_ovf = w_signed && (i_a == MIN_NEG) && (i_b == '1);

    // Before the final step the partial remainder is always below 2^(N-1), so dropping its MSB loses nothing.
    assign w_trial  = {1'b0, r_rem[N-2:0], r_quo[N-1]} - {1'b0, r_div};
    assign w_borrow = w_trial[N];

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_quo_fix = r_quo;
        w_rem_fix = r_rem;
        if (r_b_zero) begin
            w_quo_fix = '1;
            w_rem_fix = r_a_orig;
        end else if (r_ovf) begin
            w_quo_fix = r_a_orig;
            w_rem_fix = '0;
        end else begin
            if (r_sign_q) w_quo_fix = -r_quo;
            if (r_sign_r) w_rem_fix = -r_rem;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_a_orig <= '0;
            r_count  <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_b_zero <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_op     <= i_op;
                        r_quo    <= w_abs_a;
                        r_div    <= w_abs_b;
                        r_a_orig <= i_a;
                        r_rem    <= '0;
                        r_count  <= CW'(N);
                        r_sign_q <= w_signed & (i_a[N-1] ^ i_b[N-1]);
                        r_sign_r <= w_signed & i_a[N-1];
                        r_b_zero <= w_start_dbz;
                        r_ovf    <= w_start_ovf;
                        r_busy   <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        r_state  <= (w_start_dbz || w_start_ovf) ? S_FIX : S_CALC;
`else
                        r_state  <= S_CALC;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (w_borrow) begin
                        r_rem <= {r_rem[N-2:0], r_quo[N-1]};
                        r_quo <= {r_quo[N-2:0], 1'b0};
                    end else begin
                        r_rem <= w_trial[N-1:0];
                        r_quo <= {r_quo[N-2:0], 1'b1};
                    end
                    r_count <= r_count - 1'b1;
                    if (r_count == CW'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= r_op[1] ? w_rem_fix : w_quo_fix;
                    r_dbz    <= r_b_zero;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_result      = r_result;
    assign o_div_by_zero = r_dbz;

endmodule

// File: doc/divider_nbit.md
# divider_nbit

Multi-cycle iterative integer divider for the RV32M DIV/DIVU/REM/REMU instructions, computing one restoring-division quotient bit per cycle. It sits beside the single-cycle ALU in the execute stage. The pipeline launches it with a start pulse, stalls on busy, and captures the result on the one-cycle done pulse.

## Interface
- n, 32: operand and result width.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch request; sampled only in IDLE or DONE.
- op  input  2  operation: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
- A  input  n  dividend; sampled with start.
- B  input  n  divisor; sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  n  quotient or remainder, selected by the latched op; held until the next done.
- div_by_zero  output  1  latched flag, high with done when B was 0; held with result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1:
  - Latch op.
  - Latch |A| and |B|. Absolute values apply only for DIV/REM; DIVU/REMU take raw operands.
  - Latch sign_q = A[n-1]^B[n-1] and sign_r = A[n-1] (signed ops only).
  - Clear the partial remainder and load count = n.
  - Go to CALC.
- IDLE/DONE with start=0: go to or stay in IDLE.
- CALC, once per cycle:
  - Form the trial remainder {rem[n-2:0], dividend MSB} − divisor.
  - If the subtraction does not borrow, keep the difference and shift in quotient bit 1; otherwise keep the shifted remainder and shift in 0.
  - Decrement count. Go to FIX after the step where count reaches 1.
- FIX, applying overrides in priority order:
  1. B==0: quotient = all ones, remainder = A (original), div_by_zero = 1.
  2. Signed op with A = 1<<(n-1) and B = all ones: quotient = A, remainder = 0.
  3. Otherwise: negate the quotient if sign_q and negate the remainder if sign_r. Signed ops only.
  - Load result from the quotient (op[1]=0) or the remainder (op[1]=1). Go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - A start in DONE is accepted (back-to-back operation); otherwise return to IDLE.
- start in CALC or FIX is ignored; no queueing.
- Arithmetic: the trial subtraction is n+1 bits wide to capture the borrow. Negation is two's complement modulo 2^n.

## Timing
- Reset (asynchronous, any state):
  - State = IDLE.
  - busy=0, done=0, result=0, div_by_zero=0.
  - The operation in flight is discarded; no done is produced for it.
- Normal latency:
  - start sampled at edge E.
  - busy=1 from E through E+n+1 (n CALC cycles plus 1 FIX cycle).
  - done=1 and busy=0 in the cycle after edge E+n+1. Result is valid n+2 cycles after start.
- busy is low in IDLE and DONE.
- result and div_by_zero change only on the edge entering DONE; they are stable otherwise.
- Back-to-back: a start in the DONE cycle gives busy=1 in the following cycle. One idle-free operation every n+2 cycles.
- A/B/op may change freely after the sampling edge.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - Divide-by-zero and signed overflow are detected at start.
  - The FSM jumps straight to FIX, skipping CALC; done follows 2 cycles after start.
  - busy=1 for only the FIX cycle.
- DIV_EARLY_OUT_EN undefined:
  - All operations take the full n+2 cycles.
  - Result values are identical in both builds; only latency differs.

## Test plan
- DIVU, A=100, B=7 -> done at start+34 with result=14. Repeat with REMU -> result=2.
- DIV, A=0xFFFFFFF9 (−7), B=2 -> result=0xFFFFFFFD. Repeat with REM -> result=0xFFFFFFFF (−1).
- DIV, A=5, B=0 -> result=0xFFFFFFFF, div_by_zero=1. Repeat with REM -> result=5. Latency is 34 cycles without DIV_EARLY_OUT_EN and 2 cycles with it.
- DIV, A=0x80000000, B=0xFFFFFFFF -> result=0x80000000. Repeat with REM -> result=0, div_by_zero=0.
- DIVU 100/7, then start with 50/5 pulsed at cycle 10 -> ignored, result=14. Then start with 50/5 in the DONE cycle -> second done exactly 34 cycles later, result=10.
- Start DIVU 100/7, assert rst at cycle 15 -> busy/done/result go to 0 immediately and stay 0 until the next start.
